// File: rtl/fdd_motor_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fdd_motor_sequencer_pkg
// Description : Shared state encoding, 0xE0 latch bit map and helpers for the
//               FDD motor sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fdd_motor_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPINUP = 2'd1,
        ST_SETTLE = 2'd2,
        ST_READY  = 2'd3
    } fdd_state_t;

    typedef logic [11:0] ms_t;

    // Bit positions of the fields in the 0xE0 control latch.
    localparam int unsigned c_e0_bit_drive = 0;
    localparam int unsigned c_e0_bit_side  = 4;
    localparam int unsigned c_e0_bit_dden  = 5;
    localparam int unsigned c_e0_bit_led   = 6;
    localparam int unsigned c_e0_bit_motor = 7;

    function automatic logic [1:0] drive_onehot(input logic drive);
        return drive ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fdd_motor_sequencer_ms_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : ms_tick_prescaler
// Description : Divides clk_4mhz down to a 1-cycle millisecond tick; restart
//               realigns the tick phase to the edge a timer is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_prescaler
    import fdd_motor_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4000
) (
    input  logic clk_4mhz,
    input  logic RESET,
    input  logic restart,
    output logic tick
);

    localparam int unsigned c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk_4mhz or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Tick is seen on the edge that wraps the count, so a load edge plus
    // N*TICK_DIV clocks lands exactly on the Nth tick.
    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/fdd_motor_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fdd_motor_sequencer
// Description : Timed motor spin-up, head settle and idle motor-off sequencing
//               of the FDD drive-control outputs from 0xE0 requests.
// Revision    : 1.0 - initial release
// ============================================================================
module fdd_motor_sequencer
    import fdd_motor_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 4000,
    parameter int unsigned SPINUP_MS   = 500,
    parameter int unsigned SETTLE_MS   = 30,
    parameter int unsigned IDLE_OFF_MS = 2000
) (
    input  logic       clk_4mhz,
    input  logic       RESET,
    input  logic       req_valid,
    input  logic       req_motor,
    input  logic       req_drive,
    input  logic       req_side,
    input  logic       req_dden,
    input  logic       activity,
    output logic [1:0] drive_sel,
    output logic       motor_on,
    output logic       side_sel,
    output logic       dden,
    output logic       led,
    output logic       ready,
    output logic       busy
);

    localparam ms_t c_spinup_ms   = ms_t'(SPINUP_MS);
    localparam ms_t c_settle_ms   = ms_t'(SETTLE_MS);
    localparam ms_t c_idle_off_ms = ms_t'(IDLE_OFF_MS);

    fdd_state_t r_state;
    fdd_state_t w_state_next;
    ms_t        r_ms_cnt;
    ms_t        w_ms_next;
    logic       r_drive;
    logic       w_drive_next;
    logic       w_load;
    logic       w_tick;

    logic w_stop;
    logic w_run_req;
    logic w_same;
    logic w_other;
    logic w_expire;
    logic w_count;

    ms_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_4mhz (clk_4mhz),
        .RESET    (RESET),
        .restart  (w_load),
        .tick     (w_tick)
    );

    assign w_stop    = req_valid & ~req_motor;
    assign w_run_req = req_valid & req_motor;
    assign w_same    = w_run_req & (req_drive == r_drive);
    assign w_other   = w_run_req & (req_drive != r_drive);
    assign w_expire  = w_tick & (r_ms_cnt == ms_t'(1));
    assign w_count   = w_tick & (r_ms_cnt > ms_t'(1));

    // Requests that reload a timer win over a coincident terminal tick;
    // requests that leave the timer alone let the tick take effect.
    always_comb begin
        w_state_next = r_state;
        w_ms_next    = r_ms_cnt;
        w_drive_next = r_drive;
        w_load       = 1'b0;
        if (w_stop) begin
            w_state_next = ST_IDLE;
            w_ms_next    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_run_req) begin
                        w_drive_next = req_drive;
                        w_ms_next    = c_spinup_ms;
                        w_load       = 1'b1;
                        w_state_next = ST_SPINUP;
                    end
                end
                ST_SPINUP: begin
                    if (w_other) begin
                        w_drive_next = req_drive;
                    end
                    if (w_expire) begin
                        w_ms_next    = c_settle_ms;
                        w_load       = 1'b1;
                        w_state_next = ST_SETTLE;
                    end else if (w_count) begin
                        w_ms_next = r_ms_cnt - ms_t'(1);
                    end
                end
                ST_SETTLE: begin
                    if (w_other) begin
                        w_drive_next = req_drive;
                        w_ms_next    = c_settle_ms;
                        w_load       = 1'b1;
                    end else if (w_expire) begin
                        w_ms_next    = c_idle_off_ms;
                        w_load       = 1'b1;
                        w_state_next = ST_READY;
                    end else if (w_count) begin
                        w_ms_next = r_ms_cnt - ms_t'(1);
                    end
                end
                ST_READY: begin
                    if (w_other) begin
                        w_drive_next = req_drive;
                        w_ms_next    = c_settle_ms;
                        w_load       = 1'b1;
                        w_state_next = ST_SETTLE;
                    end else if (w_same || activity) begin
                        w_ms_next = c_idle_off_ms;
                        w_load    = 1'b1;
                    end else if (w_expire) begin
                        w_ms_next    = '0;
                        w_state_next = ST_IDLE;
                    end else if (w_count) begin
                        w_ms_next = r_ms_cnt - ms_t'(1);
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_ms_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_4mhz or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_ms_cnt  <= '0;
            r_drive   <= 1'b0;
            drive_sel <= 2'b00;
            motor_on  <= 1'b0;
            side_sel  <= 1'b0;
            dden      <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ms_cnt  <= w_ms_next;
            r_drive   <= w_drive_next;
            drive_sel <= (w_state_next == ST_IDLE) ? 2'b00 : drive_onehot(w_drive_next);
            motor_on  <= (w_state_next != ST_IDLE);
            ready     <= (w_state_next == ST_READY);
            busy      <= (w_state_next == ST_SPINUP) || (w_state_next == ST_SETTLE);
            if (req_valid) begin
                side_sel <= req_side;
                dden     <= req_dden;
            end
        end
    end

    assign led = motor_on;

endmodule
`default_nettype wire

// File: tb/tb_fdd_motor_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fdd_motor_sequencer
// Description : Directed and randomized bench for fdd_motor_sequencer against
//               a deadline-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fdd_motor_sequencer;

    localparam int TD = 4;
    localparam int SP = 3;
    localparam int ST = 2;
    localparam int IO = 5;

    logic       clk_4mhz  = 1'b0;
    logic       RESET     = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_motor = 1'b0;
    logic       req_drive = 1'b0;
    logic       req_side  = 1'b0;
    logic       req_dden  = 1'b0;
    logic       activity  = 1'b0;
    logic [1:0] drive_sel;
    logic       motor_on;
    logic       side_sel;
    logic       dden;
    logic       led;
    logic       ready;
    logic       busy;

    int errors = 0;
    int checks = 0;

    fdd_motor_sequencer #(
        .TICK_DIV    (TD),
        .SPINUP_MS   (SP),
        .SETTLE_MS   (ST),
        .IDLE_OFF_MS (IO)
    ) dut (
        .clk_4mhz  (clk_4mhz),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_motor (req_motor),
        .req_drive (req_drive),
        .req_side  (req_side),
        .req_dden  (req_dden),
        .activity  (activity),
        .drive_sel (drive_sel),
        .motor_on  (motor_on),
        .side_sel  (side_sel),
        .dden      (dden),
        .led       (led),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clk_4mhz = ~clk_4mhz;

    // Model: mode 0 = off, 1 = spinning up, 2 = settling, 3 = ready.
    // Each timed mode ends at an absolute edge number (deadline).
    int     m_mode     = 0;
    bit     m_drive    = 1'b0;
    bit     m_side     = 1'b0;
    bit     m_dden     = 1'b0;
    longint m_now      = 0;
    longint m_deadline = 0;

    always @(posedge clk_4mhz) begin : model_and_compare
        bit         fin;
        bit         run;
        bit         other;
        logic [7:0] exp_v;
        logic [7:0] got_v;
        m_now = m_now + 1;
        if (RESET) begin
            m_mode  = 0;
            m_drive = 1'b0;
            m_side  = 1'b0;
            m_dden  = 1'b0;
        end else begin
            fin   = (m_mode != 0) && (m_now == m_deadline);
            run   = req_valid && req_motor;
            other = run && (req_drive != m_drive);
            if (req_valid) begin
                m_side = req_side;
                m_dden = req_dden;
            end
            if (req_valid && !req_motor) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (run) begin
                    m_drive    = req_drive;
                    m_mode     = 1;
                    m_deadline = m_now + SP * TD;
                end
            end else if (m_mode == 1) begin
                if (other) m_drive = req_drive;
                if (fin) begin
                    m_mode     = 2;
                    m_deadline = m_now + ST * TD;
                end
            end else if (m_mode == 2) begin
                if (other) begin
                    m_drive    = req_drive;
                    m_deadline = m_now + ST * TD;
                end else if (fin) begin
                    m_mode     = 3;
                    m_deadline = m_now + IO * TD;
                end
            end else begin
                if (other) begin
                    m_drive    = req_drive;
                    m_mode     = 2;
                    m_deadline = m_now + ST * TD;
                end else if (run || activity) begin
                    m_deadline = m_now + IO * TD;
                end else if (fin) begin
                    m_mode = 0;
                end
            end
        end
        #1;
        exp_v[7:6] = (m_mode == 0) ? 2'b00 : (m_drive ? 2'b10 : 2'b01);
        exp_v[5]   = (m_mode != 0);
        exp_v[4]   = m_side;
        exp_v[3]   = m_dden;
        exp_v[2]   = (m_mode != 0);
        exp_v[1]   = (m_mode == 3);
        exp_v[0]   = (m_mode == 1) || (m_mode == 2);
        got_v      = {drive_sel, motor_on, side_sel, dden, led, ready, busy};
        checks     = checks + 1;
        if (got_v !== exp_v) begin
            errors = errors + 1;
            $display("FAIL model_compare t=%0t got {dsel,mot,side,dden,led,rdy,busy}=%b expected %b",
                     $time, got_v, exp_v);
        end
    end

    task automatic expect_out(input string name, input logic [1:0] dsel, input logic mot,
                              input logic rdy, input logic bsy);
        logic [5:0] got;
        logic [5:0] exp;
        got    = {drive_sel, motor_on, led, ready, busy};
        exp    = {dsel, mot, mot, rdy, bsy};
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got {dsel,mot,led,rdy,busy}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic m, input logic d, input logic s,
                        input logic dd, input logic a);
        req_valid = v;
        req_motor = m;
        req_drive = d;
        req_side  = s;
        req_dden  = dd;
        activity  = a;
        @(posedge clk_4mhz);
        @(negedge clk_4mhz);
        req_valid = 1'b0;
        activity  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk_4mhz);
        expect_out("reset_state", 2'b00, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        idle(2);

        // Side/density follow requests even in IDLE.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks = checks + 1;
        if ({side_sel, dden} !== 2'b11) begin
            errors = errors + 1;
            $display("FAIL side_dden_idle got %b expected 11", {side_sel, dden});
        end
        expect_out("stop_in_idle", 2'b00, 1'b0, 1'b0, 1'b0);

        // Full sequence on drive 0: ready at edge 20, off at edge 40.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("seq_edge0", 2'b01, 1'b1, 1'b0, 1'b1);
        idle(19);
        expect_out("seq_edge19", 2'b01, 1'b1, 1'b0, 1'b1);
        idle(1);
        expect_out("seq_edge20", 2'b01, 1'b1, 1'b1, 1'b0);
        idle(19);
        expect_out("seq_edge39", 2'b01, 1'b1, 1'b1, 1'b0);
        idle(1);
        expect_out("seq_edge40", 2'b00, 1'b0, 1'b0, 1'b0);

        // Activity keeps READY alive; off 20 clocks after the last pulse.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        for (int p = 0; p < 10; p++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            idle(9);
        end
        expect_out("act_held", 2'b01, 1'b1, 1'b1, 1'b0);
        idle(10);
        expect_out("act_last_plus19", 2'b01, 1'b1, 1'b1, 1'b0);
        idle(1);
        expect_out("act_last_plus20", 2'b00, 1'b0, 1'b0, 1'b0);

        // Drive change from READY re-settles.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("chg_edge", 2'b10, 1'b1, 1'b0, 1'b1);
        idle(7);
        expect_out("chg_plus7", 2'b10, 1'b1, 1'b0, 1'b1);
        idle(1);
        expect_out("chg_plus8", 2'b10, 1'b1, 1'b1, 1'b0);

        // Stop during SPINUP, then a full restart.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("stop_ready", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("stop_spinup_edge5", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(19);
        expect_out("restart_edge19", 2'b10, 1'b1, 1'b0, 1'b1);
        idle(1);
        expect_out("restart_edge20", 2'b10, 1'b1, 1'b1, 1'b0);

        // Drive change coincident with the settle terminal tick.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(19);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("settle_coinc_edge20", 2'b10, 1'b1, 1'b0, 1'b1);
        idle(7);
        expect_out("settle_coinc_plus7", 2'b10, 1'b1, 1'b0, 1'b1);
        idle(1);
        expect_out("settle_coinc_plus8", 2'b10, 1'b1, 1'b1, 1'b0);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0));
        end

        // Reset mid-run: outputs clear at once and stay clear.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(6);
        #1;
        RESET = 1'b1;
        #1;
        checks = checks + 1;
        if ({drive_sel, motor_on, side_sel, dden, led, ready, busy} !== 8'h00) begin
            errors = errors + 1;
            $display("FAIL async_reset got %b expected 00000000",
                     {drive_sel, motor_on, side_sel, dden, led, ready, busy});
        end
        @(negedge clk_4mhz);
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            expect_out("in_reset", 2'b00, 1'b0, 1'b0, 1'b0);
        end
        RESET = 1'b0;
        idle(3);
        expect_out("after_reset", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(19);
        expect_out("post_reset_edge19", 2'b01, 1'b1, 1'b0, 1'b1);
        idle(1);
        expect_out("post_reset_edge20", 2'b01, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
